// File: rtl/gfx_pkg.sv
// Shared graphics types: game-state encodings, fade FSM states, pixel struct
// and the game-state to background map.
package gfx_pkg;

  localparam logic [3:0] GS_MENU   = 4'b1111;
  localparam logic [3:0] GS_IDLE   = 4'b0000;
  localparam logic [3:0] GS_P1TURN = 4'b0001;
  localparam logic [3:0] GS_P2TURN = 4'b0010;
  localparam logic [3:0] GS_P1DOWN = 4'b0100;
  localparam logic [3:0] GS_P2DOWN = 4'b0101;

  localparam int unsigned RGB_W = 4;

  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_OUT  = 2'd1,
    FADE_IN   = 2'd2
  } fade_state_t;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  // The last background index is reserved and never produced here.
  function automatic logic [3:0] bg_map(input logic [3:0] gs);
    logic [3:0] idx;
    idx = 4'd0;
    case (gs)
      GS_MENU:              idx = 4'd0;
      GS_IDLE:              idx = 4'd1;
      GS_P1TURN, GS_P2TURN: idx = 4'd2;
      GS_P1DOWN:            idx = 4'd3;
      GS_P2DOWN:            idx = 4'd4;
      default:              idx = 4'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/fade_ctrl.sv
// Background selection with a frame-timed fade-out / swap / fade-in sequence
// whenever the game state maps to a different background.
module fade_ctrl
  import gfx_pkg::*;
#(
  parameter int unsigned FADE_FRAMES = 16,
  parameter int unsigned LVL_W       = $clog2(FADE_FRAMES + 1),
  parameter int unsigned BG_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [3:0]       game_state,
  output logic [LVL_W-1:0] level,
  output logic [BG_W-1:0]  cur_bg,
  output logic             fade_busy
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FADE_FRAMES);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  fade_state_t     state;
  logic [BG_W-1:0] pend_bg;
  logic [BG_W-1:0] target;

  assign target = BG_W'(bg_map(game_state));

  // Level only moves on frame_start and saturates at both ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FADE_IDLE;
      level     <= LVL_MAX;
      cur_bg    <= '0;
      pend_bg   <= '0;
      fade_busy <= 1'b0;
    end else begin
      case (state)
        FADE_IDLE: begin
          if (target != cur_bg) begin
            pend_bg   <= target;
            state     <= FADE_OUT;
            fade_busy <= 1'b1;
          end
        end
        FADE_OUT: begin
          pend_bg <= target;
          if (frame_start) begin
            if (level <= LVL_ONE) begin
              level  <= '0;
              cur_bg <= pend_bg;
              state  <= FADE_IN;
            end else begin
              level <= level - LVL_ONE;
            end
          end
        end
        FADE_IN: begin
          // A new destination reverses direction from the current level.
          if (target != cur_bg) begin
            pend_bg <= target;
            state   <= FADE_OUT;
          end else if (frame_start) begin
            if (level >= LVL_MAX - LVL_ONE) begin
              level     <= LVL_MAX;
              state     <= FADE_IDLE;
              fade_busy <= 1'b0;
            end else begin
              level <= level + LVL_ONE;
            end
          end
        end
        default: begin
          state     <= FADE_IDLE;
          fade_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel pipeline: background select, colour-keyed layer overlay,
// fade scaling and bit-replicated expansion to the VGA DAC width.
module layer_compositor
  import gfx_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = 2,
  parameter int unsigned NUM_BG      = 6,
  parameter int unsigned COLOR_W     = 4,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned FADE_FRAMES = 16
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              frame_start,
  input  logic                              pixel_valid,
  input  logic [3:0]                        game_state,
  input  logic [NUM_BG*3*COLOR_W-1:0]       bg_rgb,
  input  logic [NUM_LAYERS-1:0]             layer_en,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  output logic [OUT_W-1:0]                  VGA_R,
  output logic [OUT_W-1:0]                  VGA_G,
  output logic [OUT_W-1:0]                  VGA_B,
  output logic                              out_valid,
  output logic                              fade_busy
);

  localparam int unsigned PIX_W  = 3 * COLOR_W;
  localparam int unsigned LVL_W  = $clog2(FADE_FRAMES + 1);
  localparam int unsigned BG_W   = $clog2(NUM_BG);
  localparam int unsigned SHIFT  = $clog2(FADE_FRAMES);
  localparam int unsigned PROD_W = COLOR_W + LVL_W;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  logic [LVL_W-1:0] level;
  logic [BG_W-1:0]  cur_bg;

  fade_ctrl #(
    .FADE_FRAMES (FADE_FRAMES),
    .LVL_W       (LVL_W),
    .BG_W        (BG_W)
  ) u_fade_ctrl (
    .clk         (Clk),
    .reset       (Reset),
    .frame_start (frame_start),
    .game_state  (game_state),
    .level       (level),
    .cur_bg      (cur_bg),
    .fade_busy   (fade_busy)
  );

  pix_t bg_arr [NUM_BG];

  for (genvar i = 0; i < NUM_BG; i++) begin : g_bg
    assign bg_arr[i] = bg_rgb[i*PIX_W +: PIX_W];
  end

  // Stage 1: capture the selected background and raw layer data.
  logic                            s1_valid;
  pix_t                            s1_bg;
  logic [NUM_LAYERS-1:0]           s1_en;
  logic [NUM_LAYERS*PIX_W-1:0]     s1_layer_rgb;
  logic [LVL_W-1:0]                s1_level;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid     <= 1'b0;
      s1_bg        <= '0;
      s1_en        <= '0;
      s1_layer_rgb <= '0;
      s1_level     <= LVL_W'(FADE_FRAMES);
    end else begin
      s1_valid     <= pixel_valid;
      s1_bg        <= bg_arr[cur_bg];
      s1_en        <= layer_en;
      s1_layer_rgb <= layer_rgb;
      s1_level     <= level;
    end
  end

  pix_t lay_arr [NUM_LAYERS];

  for (genvar j = 0; j < NUM_LAYERS; j++) begin : g_lay
    assign lay_arr[j] = s1_layer_rgb[j*PIX_W +: PIX_W];
  end

  // All-zero colour is the transparency key; later layers win.
  pix_t comp;

  always_comb begin
    comp = s1_bg;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (s1_en[i] && (lay_arr[i] != '0)) comp = lay_arr[i];
    end
  end

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [LVL_W-1:0]   lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'(lvl);
    return COLOR_W'(prod >> SHIFT);
  endfunction

  logic [COLOR_W-1:0] sc_r, sc_g, sc_b;
  logic [OUT_W-1:0]   ex_r, ex_g, ex_b;

  assign sc_r = scale(comp.r, s1_level);
  assign sc_g = scale(comp.g, s1_level);
  assign sc_b = scale(comp.b, s1_level);

  // Replicate MSB-first so full scale maps to full scale.
  for (genvar k = 0; k < OUT_W; k++) begin : g_expand
    assign ex_r[OUT_W-1-k] = sc_r[COLOR_W-1-(k % COLOR_W)];
    assign ex_g[OUT_W-1-k] = sc_g[COLOR_W-1-(k % COLOR_W)];
    assign ex_b[OUT_W-1-k] = sc_b[COLOR_W-1-(k % COLOR_W)];
  end

  // Stage 2: output registers, blanked when the pixel is not visible.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      out_valid <= s1_valid;
      VGA_R     <= s1_valid ? ex_r : '0;
      VGA_G     <= s1_valid ? ex_g : '0;
      VGA_B     <= s1_valid ? ex_b : '0;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor with FADE_FRAMES=4: a behavioural model checked
// every cycle plus hand-computed literal checkpoints.
module tb_layer_compositor;
  import gfx_pkg::*;

  localparam int FF = 4;
  localparam int NL = 2;
  localparam int NB = 6;

  logic        Clk;
  logic        Reset;
  logic        frame_start;
  logic        pixel_valid;
  logic [3:0]  game_state;
  logic [NB*12-1:0] bg_rgb;
  logic [NL-1:0]    layer_en;
  logic [NL*12-1:0] layer_rgb;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        out_valid;
  logic        fade_busy;

  rgb_t bgs  [NB];
  rgb_t lays [NL];

  for (genvar i = 0; i < NB; i++) begin : g_pack_bg
    assign bg_rgb[i*12 +: 12] = bgs[i];
  end
  for (genvar i = 0; i < NL; i++) begin : g_pack_lay
    assign layer_rgb[i*12 +: 12] = lays[i];
  end

  layer_compositor #(
    .NUM_LAYERS  (NL),
    .NUM_BG      (NB),
    .COLOR_W     (4),
    .OUT_W       (8),
    .FADE_FRAMES (FF)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .game_state  (game_state),
    .bg_rgb      (bg_rgb),
    .layer_en    (layer_en),
    .layer_rgb   (layer_rgb),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .out_valid   (out_valid),
    .fade_busy   (fade_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Model: brightness m_lvl of FF, shown background m_cur, queued m_pend,
  // m_dir = 0 steady, -1 dimming, +1 brightening.
  int m_lvl = FF, m_cur = 0, m_pend = 0, m_dir = 0;
  logic [24:0] m_s1  = '0;
  logic [24:0] m_out = '0;

  function automatic int tgt_of(input logic [3:0] gs);
    case (gs)
      4'b1111: return 0;
      4'b0000: return 1;
      4'b0001, 4'b0010: return 2;
      4'b0100: return 3;
      4'b0101: return 4;
      default: return 0;
    endcase
  endfunction

  // 4-bit to 8-bit by replication is multiplication by 17.
  function automatic logic [7:0] ch(input int c, input int lvl);
    return 8'(((c * lvl) / FF) * 17);
  endfunction

  always @(posedge Clk) begin : model
    rgb_t col;
    int   t;
    if (Reset) begin
      m_out = '0; m_s1 = '0;
      m_lvl = FF; m_cur = 0; m_pend = 0; m_dir = 0;
    end else begin
      m_out = m_s1;
      col = bgs[m_cur];
      for (int k = 0; k < NL; k++)
        if (layer_en[k] && lays[k] != '0) col = lays[k];
      m_s1 = pixel_valid ? {1'b1, ch(int'(col.r), m_lvl), ch(int'(col.g), m_lvl),
                            ch(int'(col.b), m_lvl)} : 25'd0;
      t = tgt_of(game_state);
      if (m_dir == 0) begin
        if (t != m_cur) begin m_pend = t; m_dir = -1; end
      end else if (m_dir < 0) begin
        if (frame_start) begin
          if (m_lvl > 0) m_lvl = m_lvl - 1;
          if (m_lvl == 0) begin m_cur = m_pend; m_dir = 1; end
        end
        m_pend = t;
      end else begin
        if (t != m_cur) begin
          m_pend = t; m_dir = -1;
        end else if (frame_start) begin
          if (m_lvl < FF) m_lvl = m_lvl + 1;
          if (m_lvl == FF) m_dir = 0;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      n_assert++;
      if ({out_valid, VGA_R, VGA_G, VGA_B} !== m_out) begin
        n_fail++;
        $display("FAIL pixel @%0t: got v=%b %h_%h_%h, want v=%b %h_%h_%h", $time,
                 out_valid, VGA_R, VGA_G, VGA_B, m_out[24], m_out[23:16], m_out[15:8], m_out[7:0]);
      end
      n_assert++;
      if (fade_busy !== (m_dir != 0)) begin
        n_fail++;
        $display("FAIL fade_busy @%0t: got %b, want %b", $time, fade_busy, (m_dir != 0));
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    step(3);
  endtask

  int bf;
  int exp_out[4];
  int exp_in[4];

  initial begin
    Reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0;
    game_state = 4'b1111; layer_en = '0;
    for (int i = 0; i < NB; i++) bgs[i] = '0;
    for (int i = 0; i < NL; i++) lays[i] = '0;
    step(3);
    chk_on = 1'b1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_fade_busy", int'(fade_busy), 0);
    check("reset_vga_r", int'(VGA_R), 0);

    // Plain background and blanking.
    Reset = 1'b0;
    bgs[0] = {4'hF, 4'hF, 4'hF};
    bgs[1] = {4'hC, 4'hC, 4'hC};
    bgs[2] = {4'h3, 4'h6, 4'h9};
    bgs[3] = {4'h4, 4'h4, 4'h4};
    bgs[4] = {4'hF, 4'h0, 4'hA};
    pixel_valid = 1'b1;
    step(2);
    check("bg0_valid", int'(out_valid), 1);
    check("bg0_r", int'(VGA_R), 'hFF);
    check("bg0_g", int'(VGA_G), 'hFF);
    check("bg0_b", int'(VGA_B), 'hFF);
    pixel_valid = 1'b0;
    step(2);
    check("blank_valid", int'(out_valid), 0);
    check("blank_r", int'(VGA_R), 0);

    // Layer priority and transparency key.
    pixel_valid = 1'b1;
    lays[0] = {4'h1, 4'h2, 4'h3};
    lays[1] = {4'h5, 4'h5, 4'h5};
    layer_en = 2'b11;
    step(2);
    check("prio_r", int'(VGA_R), 'h55);
    check("prio_b", int'(VGA_B), 'h55);
    lays[1] = '0;
    step(2);
    check("key_r", int'(VGA_R), 'h11);
    check("key_g", int'(VGA_G), 'h22);
    check("key_b", int'(VGA_B), 'h33);
    layer_en = 2'b00;
    step(2);
    check("noen_r", int'(VGA_R), 'hFF);

    // Unmapped state from MENU keeps background 0.
    game_state = 4'b1010;
    step(4);
    check("unmapped_busy", int'(fade_busy), 0);
    game_state = 4'b1111;
    step(2);

    // Full fade MENU -> IDLE.
    bgs[0] = {4'h8, 4'h8, 4'h8};
    exp_out = '{'h66, 'h44, 'h22, 'h00};
    exp_in  = '{'h33, 'h66, 'h99, 'hCC};
    game_state = 4'b0000;
    step(2);
    check("fade_start_busy", int'(fade_busy), 1);
    bf = 0;
    for (int i = 0; i < 4; i++) begin
      if (fade_busy) bf++;
      frame_pulse();
      check("fade_out_r", int'(VGA_R), exp_out[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (fade_busy) bf++;
      frame_pulse();
      check("fade_in_r", int'(VGA_R), exp_in[i]);
    end
    check("fade_busy_frames", bf, 8);
    check("fade_done_busy", int'(fade_busy), 0);

    // State change coinciding with frame_start: no decrement on that pulse.
    game_state = 4'b0001;
    frame_pulse();
    check("coincide_r", int'(VGA_R), 'hCC);
    for (int i = 0; i < 8; i++) frame_pulse();
    check("p1turn_r", int'(VGA_R), 'h33);
    game_state = 4'b0010;
    step(4);
    check("p2turn_busy", int'(fade_busy), 0);

    // Retarget during fade-in at level 2.
    game_state = 4'b0100;
    step(2);
    for (int i = 0; i < 6; i++) frame_pulse();
    check("retgt_lvl2_r", int'(VGA_R), 'h22);
    game_state = 4'b0101;
    step(2);
    check("retgt_hold_r", int'(VGA_R), 'h22);
    check("retgt_busy", int'(fade_busy), 1);
    frame_pulse();
    check("retgt_lvl1_r", int'(VGA_R), 'h11);
    frame_pulse();
    check("retgt_lvl0_r", int'(VGA_R), 'h00);
    for (int i = 0; i < 4; i++) frame_pulse();
    check("bg4_r", int'(VGA_R), 'hFF);
    check("bg4_g", int'(VGA_G), 'h00);
    check("bg4_b", int'(VGA_B), 'hAA);

    // Reset in the middle of a fade-out at level 1.
    game_state = 4'b1111;
    step(2);
    for (int i = 0; i < 3; i++) frame_pulse();
    Reset = 1'b1;
    step(1);
    check("midreset_valid", int'(out_valid), 0);
    check("midreset_busy", int'(fade_busy), 0);
    Reset = 1'b0;
    step(2);
    check("postreset_r", int'(VGA_R), 'h88);
    check("postreset_busy", int'(fade_busy), 0);
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
